// File: rtl/dram_cache_write_arbiter.sv
// -----------------------------------------------------------------------------
// dram_cache_write_arbiter
//
// Shares one set of AXI write channels (AW/W/B) between two line writers:
//   port 0 (fill)   : tag-compare fill path, lines are written dirty
//   port 1 (refill) : memory refill path, lines are written clean
// Each accepted request becomes one single-beat AXI write. The block builds
// the tag word, maps the index to a DRAM-cache line address and counts
// writes whose B response has not yet arrived.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   fill_valid_i/ready_o       port 0 request handshake
//   fill_data_i                port 0 {addr, data}
//   refill_valid_i/ready_o     port 1 request handshake
//   refill_data_i              port 1 {addr, data}
//   awid_o                     {granted port, 15-bit sequence count}
//   awaddr_o                   index * LINE_BYTES
//   awvalid_o / awready_i      AW handshake
//   wdata_o                    {tag word, line data}
//   wlast_o                    equals wvalid_o (single beat)
//   wvalid_o / wready_i        W handshake
//   bid_i, bresp_i             B response (bid_i is not used)
//   bvalid_i / bready_o        B handshake, bready_o is 1 once out of reset
//   err_o                      sticky error (bad bresp_i or B with none due)
//   busy_o                     FSM not idle or writes outstanding
//   dbg_state_o                1 while in S_SEND
//   dbg_outstanding_o          current outstanding write count
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A source holds valid and its payload stable until that edge;
// ready may depend on valid. The request ready outputs are combinational
// from the request valids (grant), and AW/W hold their payload until their
// own channel completes.
// -----------------------------------------------------------------------------
module dram_cache_write_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 512,
  parameter int TAG_S      = 64,
  parameter int TAG_W      = 16,
  parameter int INDEX_W    = 10,
  parameter int OFFSET_W   = 38,
  parameter int BLANK_W    = 46,
  parameter int ID_W       = 16,
  parameter int LINE_BYTES = 128,
  parameter int MAX_OUT    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fill_valid_i,
  output logic                       fill_ready_o,
  input  logic [ADDR_W+DATA_W-1:0]   fill_data_i,
  input  logic                       refill_valid_i,
  output logic                       refill_ready_o,
  input  logic [ADDR_W+DATA_W-1:0]   refill_data_i,
  output logic [ID_W-1:0]            awid_o,
  output logic [ADDR_W-1:0]          awaddr_o,
  output logic                       awvalid_o,
  input  logic                       awready_i,
  output logic [TAG_S+DATA_W-1:0]    wdata_o,
  output logic                       wlast_o,
  output logic                       wvalid_o,
  input  logic                       wready_i,
  input  logic [ID_W-1:0]            bid_i,
  input  logic [1:0]                 bresp_i,
  input  logic                       bvalid_i,
  output logic                       bready_o,
  output logic                       err_o,
  output logic                       busy_o,
  output logic                       dbg_state_o,
  output logic [$clog2(MAX_OUT+1)-1:0] dbg_outstanding_o
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam int SEQ_W = ID_W - 1;
  localparam logic [CNT_W-1:0]  MAX_OUT_C    = CNT_W'(MAX_OUT);
  localparam logic [ADDR_W-1:0] LINE_BYTES_C = ADDR_W'(LINE_BYTES);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t              state, state_nxt;
  logic                aw_pend, aw_pend_nxt;   // AW still to be handed off
  logic                w_pend, w_pend_nxt;     // W still to be handed off
  logic [CNT_W-1:0]    out_cnt;
  logic [SEQ_W-1:0]    seq;
  logic                rr_last;                // port granted most recently
  logic                run;                    // low for the first cycle after reset

  logic                accept;
  logic                gnt_port;
  logic [ADDR_W+DATA_W-1:0] sel_req;
  logic [ADDR_W-1:0]   sel_addr;
  logic [TAG_S-1:0]    tag_word;
  logic                aw_hs, w_hs, b_hs;

  assign aw_hs = aw_pend & awready_i;
  assign w_hs  = w_pend  & wready_i;
  assign b_hs  = bvalid_i & bready_o;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
    end else begin
      state   <= state_nxt;
      aw_pend <= aw_pend_nxt;
      w_pend  <= w_pend_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state, grant and request ready outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt      = state;
    aw_pend_nxt    = aw_pend;
    w_pend_nxt     = w_pend;
    fill_ready_o   = 1'b0;
    refill_ready_o = 1'b0;
    accept         = 1'b0;
    gnt_port       = 1'b0;
    case (state)
      S_IDLE: begin
        if (run && (out_cnt < MAX_OUT_C) && (fill_valid_i || refill_valid_i)) begin
          // On contention the port that did not win last time goes next.
          if (fill_valid_i && refill_valid_i) gnt_port = ~rr_last;
          else                                gnt_port = refill_valid_i;
          fill_ready_o   = ~gnt_port;
          refill_ready_o = gnt_port;
          accept         = 1'b1;
          aw_pend_nxt    = 1'b1;
          w_pend_nxt     = 1'b1;
          state_nxt      = S_SEND;
        end
      end
      S_SEND: begin
        if (aw_hs) aw_pend_nxt = 1'b0;
        if (w_hs)  w_pend_nxt  = 1'b0;
        if (!aw_pend_nxt && !w_pend_nxt) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  assign sel_req  = gnt_port ? refill_data_i : fill_data_i;
  assign sel_addr = sel_req[ADDR_W+DATA_W-1:DATA_W];

  // {valid, dirty, address tag, zero padding}; only fill writes are dirty.
  assign tag_word = {1'b1, ~gnt_port, sel_addr[OFFSET_W+INDEX_W +: TAG_W], {BLANK_W{1'b0}}};

  // The offset bits and the B ID carry no information for this block.
  logic unused_bits;
  assign unused_bits = ^{bid_i, sel_addr[OFFSET_W-1:0]};

  // ---------------------------------------------------------------------------
  // Write payload registers, held until the next accepted request
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awaddr_o <= '0;
      awid_o   <= '0;
      wdata_o  <= '0;
      seq      <= '0;
      rr_last  <= 1'b1;
    end else if (accept) begin
      awaddr_o <= ADDR_W'(sel_addr[OFFSET_W +: INDEX_W]) * LINE_BYTES_C;
      awid_o   <= {gnt_port, seq};
      wdata_o  <= {tag_word, sel_req[DATA_W-1:0]};
      seq      <= seq + SEQ_W'(1);
      rr_last  <= gnt_port;
    end
  end

  // ---------------------------------------------------------------------------
  // Outstanding write counter, error flag and B ready
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt <= '0;
      err_o   <= 1'b0;
      run     <= 1'b0;
    end else begin
      run <= 1'b1;
      if (aw_hs && !b_hs) begin
        out_cnt <= out_cnt + CNT_W'(1);
      end else if (b_hs && !aw_hs) begin
        // A response with nothing outstanding is dropped and flagged.
        if (out_cnt == '0) err_o <= 1'b1;
        else               out_cnt <= out_cnt - CNT_W'(1);
      end
      if (b_hs && (bresp_i != 2'b00)) err_o <= 1'b1;
    end
  end

  assign awvalid_o         = aw_pend;
  assign wvalid_o          = w_pend;
  assign wlast_o           = w_pend;
  assign bready_o          = run;
  assign busy_o            = (state != S_IDLE) || (out_cnt != '0);
  assign dbg_state_o       = (state == S_SEND);
  assign dbg_outstanding_o = out_cnt;

endmodule
